// File: rtl/ren_pkg.sv
// Shared types and constants for the tile scheduler: tile and edge records,
// the scheduler state encoding and the default geometry.
package ren_pkg;

  localparam int REN_COORD_W    = 16;
  localparam int REN_TILE_SHIFT = 3;
  localparam int REN_SIZE_W     = 8;
  localparam int REN_EDGE_W     = 32;

  localparam logic [REN_SIZE_W-1:0] fpTILE_SIZE = REN_SIZE_W'(1 << REN_TILE_SHIFT);

  // Edge function E(x,y) = a*x + b*y + c, coefficients straight from setup.
  typedef struct packed {
    logic signed [REN_EDGE_W-1:0] a;
    logic signed [REN_EDGE_W-1:0] b;
    logic signed [REN_EDGE_W-1:0] c;
  } edge_t;

  typedef struct packed {
    logic [REN_COORD_W-1:0] x;
    logic [REN_COORD_W-1:0] y;
    logic [REN_SIZE_W-1:0]  size;
  } tile_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ISSUE,
    DONE
  } sched_state_e;

endpackage

// File: rtl/ren_tile_walker.sv
// Raster-order tile cursor: loads the aligned bbox origin, steps one tile per
// accepted handshake and flags the final tile of the box.
module ren_tile_walker
  import ren_pkg::*;
#(
  parameter int COORD_W    = REN_COORD_W,
  parameter int TILE_SHIFT = REN_TILE_SHIFT
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic signed [COORD_W-1:0] xmin_al,
  input  logic signed [COORD_W-1:0] xmax_al,
  input  logic signed [COORD_W-1:0] ymin_al,
  input  logic signed [COORD_W-1:0] ymax_al,
  input  logic                      load,
  input  logic                      step,
  output logic signed [COORD_W-1:0] x,
  output logic signed [COORD_W-1:0] y,
  output logic                      last
);

  localparam logic signed [COORD_W-1:0] TILE = COORD_W'(1 << TILE_SHIFT);

  logic signed [COORD_W-1:0] x_q, x_d;
  logic signed [COORD_W-1:0] y_q, y_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load) begin
      x_d = xmin_al;
      y_d = ymin_al;
    end else if (step) begin
      if (x_q == xmax_al) begin
        x_d = xmin_al;
        y_d = y_q + TILE;
      end else begin
        x_d = x_q + TILE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xmax_al) && (y_q == ymax_al);

endmodule

// File: rtl/ren_tile_scheduler.sv
// Tile scheduler: accepts one triangle, clamps and tile-aligns its bbox, then
// hands tiles plus the triangle's edge functions to the rasterizer.
module ren_tile_scheduler
  import ren_pkg::*;
#(
  parameter int COORD_W    = REN_COORD_W,
  parameter int TILE_SHIFT = REN_TILE_SHIFT,
  parameter int SCREEN_W   = 64,
  parameter int SCREEN_H   = 64,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_en,
  input  logic                      i_tri_valid,
  output logic                      o_tri_ready,
  input  logic signed [COORD_W-1:0] i_bbox_xmin,
  input  logic signed [COORD_W-1:0] i_bbox_xmax,
  input  logic signed [COORD_W-1:0] i_bbox_ymin,
  input  logic signed [COORD_W-1:0] i_bbox_ymax,
  input  edge_t                     i_e0_edge,
  input  edge_t                     i_e1_edge,
  input  edge_t                     i_e2_edge,
  output logic                      o_valid,
  input  logic                      i_busy_r,
  output tile_t                     o_tile,
  output edge_t                     o_e0_edge,
  output edge_t                     o_e1_edge,
  output edge_t                     o_e2_edge,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [CNT_W-1:0]          o_tile_count
);

  localparam logic signed [COORD_W-1:0] XLIM = COORD_W'(SCREEN_W - 1);
  localparam logic signed [COORD_W-1:0] YLIM = COORD_W'(SCREEN_H - 1);

  sched_state_e state_q, state_d;

  logic signed [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
  edge_t                     e0_q, e1_q, e2_q;
  logic [CNT_W-1:0]          cnt_q;

  logic tri_accept, tile_accept, empty, load, step, last;
  logic signed [COORD_W-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic signed [COORD_W-1:0] xmin_al, xmax_al, ymin_al, ymax_al;
  logic signed [COORD_W-1:0] walk_x, walk_y;

  assign o_tri_ready = (state_q == IDLE) && i_en;
  assign tri_accept  = i_tri_valid && o_tri_ready;
  assign o_valid     = (state_q == ISSUE);
  assign tile_accept = o_valid && !i_busy_r;

  // Clamp to the screen using signed compares, then drop to the enclosing tile.
  assign xmin_c = xmin_q[COORD_W-1] ? '0 : xmin_q;
  assign ymin_c = ymin_q[COORD_W-1] ? '0 : ymin_q;
  assign xmax_c = (xmax_q > XLIM) ? XLIM : xmax_q;
  assign ymax_c = (ymax_q > YLIM) ? YLIM : ymax_q;
  assign empty  = (xmin_c > xmax_c) || (ymin_c > ymax_c);

  assign xmin_al = {xmin_c[COORD_W-1:TILE_SHIFT], {TILE_SHIFT{1'b0}}};
  assign xmax_al = {xmax_c[COORD_W-1:TILE_SHIFT], {TILE_SHIFT{1'b0}}};
  assign ymin_al = {ymin_c[COORD_W-1:TILE_SHIFT], {TILE_SHIFT{1'b0}}};
  assign ymax_al = {ymax_c[COORD_W-1:TILE_SHIFT], {TILE_SHIFT{1'b0}}};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE:  if (tri_accept) state_d = SETUP;
      SETUP: begin
        if (empty) begin
          state_d = DONE;
        end else begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (tile_accept) begin
          step = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      e0_q   <= '0;
      e1_q   <= '0;
      e2_q   <= '0;
      cnt_q  <= '0;
    end else if (tri_accept) begin
      xmin_q <= i_bbox_xmin;
      xmax_q <= i_bbox_xmax;
      ymin_q <= i_bbox_ymin;
      ymax_q <= i_bbox_ymax;
      e0_q   <= i_e0_edge;
      e1_q   <= i_e1_edge;
      e2_q   <= i_e2_edge;
      cnt_q  <= '0;
    end else if (tile_accept && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  ren_tile_walker #(
    .COORD_W    (COORD_W),
    .TILE_SHIFT (TILE_SHIFT)
  ) u_walker (
    .clk     (clk),
    .rstn    (rstn),
    .xmin_al (xmin_al),
    .xmax_al (xmax_al),
    .ymin_al (ymin_al),
    .ymax_al (ymax_al),
    .load    (load),
    .step    (step),
    .x       (walk_x),
    .y       (walk_y),
    .last    (last)
  );

  assign o_tile.x     = walk_x;
  assign o_tile.y     = walk_y;
  assign o_tile.size  = o_valid ? fpTILE_SIZE : '0;
  assign o_e0_edge    = e0_q;
  assign o_e1_edge    = e1_q;
  assign o_e2_edge    = e2_q;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);
  assign o_tile_count = cnt_q;

endmodule

// File: tb/tb_ren_tile_scheduler.sv
// Bench for ren_tile_scheduler: directed walks plus randomized triangles and
// back-pressure, scored against a plain-arithmetic list of expected tiles.
module tb_ren_tile_scheduler;
  import ren_pkg::*;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              i_en = 1'b0;
  logic              i_tri_valid = 1'b0;
  logic              o_tri_ready;
  logic signed [15:0] i_bbox_xmin = '0, i_bbox_xmax = '0, i_bbox_ymin = '0, i_bbox_ymax = '0;
  edge_t             i_e0_edge = '0, i_e1_edge = '0, i_e2_edge = '0;
  logic              o_valid;
  logic              i_busy_r = 1'b0;
  tile_t             o_tile;
  edge_t             o_e0_edge, o_e1_edge, o_e2_edge;
  logic              o_busy, o_done;
  logic [15:0]       o_tile_count;

  int passed = 0;
  int total  = 0;

  typedef struct {int x; int y;} xy_t;
  xy_t exp_q[$];

  always #5 clk = ~clk;

  ren_tile_scheduler dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_en         (i_en),
    .i_tri_valid  (i_tri_valid),
    .o_tri_ready  (o_tri_ready),
    .i_bbox_xmin  (i_bbox_xmin),
    .i_bbox_xmax  (i_bbox_xmax),
    .i_bbox_ymin  (i_bbox_ymin),
    .i_bbox_ymax  (i_bbox_ymax),
    .i_e0_edge    (i_e0_edge),
    .i_e1_edge    (i_e1_edge),
    .i_e2_edge    (i_e2_edge),
    .o_valid      (o_valid),
    .i_busy_r     (i_busy_r),
    .o_tile       (o_tile),
    .o_e0_edge    (o_e0_edge),
    .o_e1_edge    (o_e1_edge),
    .o_e2_edge    (o_e2_edge),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_tile_count (o_tile_count)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: clip to the 64x64 screen, then enumerate every 8x8 tile the
  // clipped box touches, row by row.
  function automatic void build_model(input int xmin, input int xmax, input int ymin, input int ymax);
    int xl, xh, yl, yh;
    exp_q.delete();
    xl = (xmin < 0) ? 0 : xmin;
    yl = (ymin < 0) ? 0 : ymin;
    xh = (xmax > 63) ? 63 : xmax;
    yh = (ymax > 63) ? 63 : ymax;
    if (xl > xh || yl > yh) return;
    for (int ty = (yl / 8) * 8; ty <= yh; ty += 8)
      for (int tx = (xl / 8) * 8; tx <= xh; tx += 8)
        exp_q.push_back('{x: tx, y: ty});
  endfunction

  // busy_mode: 0 never busy, 1 busy 3 cycles on the second tile, 2 random.
  // rst_at >= 0 pulls reset while that tile index is presented and aborts.
  task automatic run_tri(input int xmin, input int xmax, input int ymin, input int ymax,
                         input int busy_mode, input bit toggle_en, input int rst_at);
    edge_t e0, e1, e2;
    int    n, idx, cyc, stall;
    bit    b;
    e0 = {$urandom, $urandom, $urandom};
    e1 = {$urandom, $urandom, $urandom};
    e2 = {$urandom, $urandom, $urandom};
    build_model(xmin, xmax, ymin, ymax);
    n = exp_q.size();

    @(negedge clk);
    check("ready_before_accept", o_tri_ready, 1'b1);
    check("idle_not_busy", o_busy, 1'b0);
    i_tri_valid = 1'b1;
    i_bbox_xmin = 16'(xmin);
    i_bbox_xmax = 16'(xmax);
    i_bbox_ymin = 16'(ymin);
    i_bbox_ymax = 16'(ymax);
    i_e0_edge = e0;
    i_e1_edge = e1;
    i_e2_edge = e2;

    @(negedge clk);
    i_tri_valid = 1'b0;
    i_bbox_xmin = 16'($urandom);
    i_e0_edge   = '0;
    check("setup_busy", o_busy, 1'b1);
    check("setup_no_valid", o_valid, 1'b0);
    check("setup_ready_low", o_tri_ready, 1'b0);
    check("count_cleared", o_tile_count, 16'd0);
    if (toggle_en) i_en = 1'($urandom);

    idx = 0; cyc = 0; stall = 0;
    while (idx < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (idx == rst_at) begin
        #2 rstn = 1'b0;
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_count", o_tile_count, 16'd0);
        check("rst_tile", o_tile, '0);
        check("rst_edge", o_e0_edge, '0);
        repeat (2) begin
          @(negedge clk);
          check("rst_no_done", o_done, 1'b0);
        end
        rstn = 1'b1;
        i_busy_r = 1'b0;
        i_en = 1'b1;
        return;
      end
      case (busy_mode)
        1:       b = (idx == 1) && (stall < 3);
        2:       b = ($urandom_range(0, 2) == 0);
        default: b = 1'b0;
      endcase
      if (b) stall++;
      i_busy_r = b;
      check("tile_valid", o_valid, 1'b1);
      check("tile_x", o_tile.x, 128'(exp_q[idx].x));
      check("tile_y", o_tile.y, 128'(exp_q[idx].y));
      check("tile_size", o_tile.size, 128'(8));
      check("walk_no_done", o_done, 1'b0);
      check("walk_count", o_tile_count, 128'(idx));
      check("e0", o_e0_edge, e0);
      check("e1", o_e1_edge, e1);
      check("e2", o_e2_edge, e2);
      if (!b) idx++;
      if (toggle_en) i_en = 1'($urandom);
    end
    if (cyc >= 2000) check("walk_timeout", 1'b0, 1'b1);

    @(negedge clk);
    i_busy_r = 1'b0;
    i_en = 1'b1;
    check("done_pulse", o_done, 1'b1);
    check("done_no_valid", o_valid, 1'b0);
    check("done_count", o_tile_count, 128'(n));
  endtask

  initial begin
    #12;
    check("reset_valid", o_valid, 1'b0);
    check("reset_busy", o_busy, 1'b0);
    check("reset_done", o_done, 1'b0);
    check("reset_ready", o_tri_ready, 1'b0);
    check("reset_tile", o_tile, '0);
    check("reset_edges", {o_e0_edge, o_e1_edge[31:0]}, '0);
    check("reset_count", o_tile_count, 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    i_en = 1'b1;

    run_tri(3, 20, 5, 9, 0, 1'b0, -1);          // basic walk, 6 tiles
    run_tri(3, 20, 5, 9, 1, 1'b0, -1);          // stall on (8,0)
    run_tri(-10, 70, 60, 100, 0, 1'b0, -1);     // clamped row of 8
    run_tri(70, 80, 0, 10, 0, 1'b0, -1);        // off-screen, empty
    run_tri(9, 9, 9, 9, 0, 1'b0, -1);           // single tile (8,8)

    @(negedge clk);
    i_en = 1'b0;
    i_tri_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("en_low_ready", o_tri_ready, 1'b0);
      check("en_low_no_accept", o_busy, 1'b0);
    end
    i_tri_valid = 1'b0;
    i_en = 1'b1;

    run_tri(3, 20, 5, 9, 0, 1'b0, 2);           // reset during third tile
    run_tri(3, 20, 5, 9, 0, 1'b0, -1);          // accepted after release
    run_tri(-30, -1, 0, 20, 0, 1'b0, -1);       // entirely left of screen

    for (int i = 0; i < 25; i++) begin
      int x0, y0;
      x0 = int'($urandom_range(0, 110)) - 20;
      y0 = int'($urandom_range(0, 110)) - 20;
      run_tri(x0, x0 + int'($urandom_range(0, 45)) - 5,
              y0, y0 + int'($urandom_range(0, 45)) - 5, 2, 1'b1, -1);
    end

    @(negedge clk);
    check("final_idle", o_busy, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
